bcd_to_bin: RTL

BCD_TO_BIN -- requirements
Module: bcd_to_bin

---
 rtl/bcd_to_bin_if.sv | 15 +
 rtl/bcd_to_bin.sv | 96 +++++++++
 2 files changed

// File: rtl/bcd_to_bin_if.sv
// Request/result bundle for the iterative BCD-to-binary converter.
interface bcd_to_bin_if #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned BW     = 20
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BW-1:0]         bin;

  modport master (output start, bcd, input busy, done, err, bin);
  modport slave  (input start, bcd, output busy, done, err, bin);
endinterface

// File: rtl/bcd_to_bin.sv
// Packed-BCD to binary converter: one reverse double-dabble shift per cycle,
// BW iterations, then a one-cycle done pulse with the registered result.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned BW     = 20
) (
  input  logic          clk,
  input  logic          clr,
  bcd_to_bin_if.slave   bus
);

  localparam int unsigned BCDW = 4 * DIGITS;
  localparam int unsigned SRW  = BCDW + BW;
  localparam int unsigned CW   = $clog2(BW + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state;
  logic [SRW-1:0]  sr;
  logic [CW-1:0]   cnt;
  logic            bad_pend;

  logic [SRW-1:0]  sr_shift_c;
  logic [SRW-1:0]  sr_step_c;
  logic            bad_digit_c;

  // One iteration: shift right, then pull every BCD field >= 8 back by 3.
  always_comb begin
    sr_shift_c = sr >> 1;
    sr_step_c  = sr_shift_c;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_shift_c[BW + 4*i +: 4] >= 4'd8)
        sr_step_c[BW + 4*i +: 4] = sr_shift_c[BW + 4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    bad_digit_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.bcd[4*i +: 4] > 4'd9) bad_digit_c = 1'b1;
    end
  end

  // bad_pend holds IDLE for one cycle so an invalid request reports done
  // one cycle after acceptance without ever raising busy.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      sr       <= '0;
      cnt      <= '0;
      bad_pend <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      bus.bin  <= '0;
    end else begin
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (bad_pend) begin
            bad_pend <= 1'b0;
            state    <= DONE;
            bus.done <= 1'b1;
          end else if (bus.start) begin
            if (bad_digit_c) begin
              bad_pend <= 1'b1;
              bus.err  <= 1'b1;
              bus.bin  <= '0;
            end else begin
              sr       <= {bus.bcd, BW'(0)};
              cnt      <= '0;
              bus.err  <= 1'b0;
              bus.busy <= 1'b1;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          if (cnt == CW'(BW)) begin
            bus.bin  <= sr[BW-1:0];
            bus.done <= 1'b1;
            state    <= DONE;
          end else begin
            sr       <= sr_step_c;
            cnt      <= cnt + CW'(1);
            bus.busy <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
